weight_axi_ctrl: RTL and testbench

WEIGHT_AXI_CTRL -- requirements
Module: weight_axi_ctrl

---
 rtl/ising_pkg.sv | 23 ++
 rtl/weight_addr_decode.sv | 35 +++
 rtl/weight_axi_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_weight_axi_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ising_pkg.sv
// Shared definitions for the Ising weight array AXI-lite controller.
// Holds the AXI response codes and the write/read channel state encodings
// used by weight_axi_ctrl.
package ising_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_STROBE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/weight_addr_decode.sv
// Byte address to cell one-hot decode with range check.
// Ports:
//   addr      in   32     byte address from the AXI-lite channel
//   match     out  N*N    one-hot cell select (index row*N+col), zero if out of range
//   in_range  out  1      address maps to an existing cell
module weight_addr_decode
    import ising_pkg::*;
#(
    parameter int          N         = 8,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic [31:0]    addr,
    output logic [N*N-1:0] match,
    output logic           in_range
);

    localparam int CELLS = N * N;

    logic [31:0] offset;
    logic [31:0] index;

    // Byte lane bits drop out in the shift; an address below the base wraps
    // to a huge offset but is rejected explicitly anyway.
    assign offset   = addr - ADDR_BASE;
    assign index    = offset >> 2;
    assign in_range = (addr >= ADDR_BASE) && (index < 32'(CELLS));

    always_comb begin
        match = '0;
        for (int k = 0; k < CELLS; k++) begin
            match[k] = in_range && (index == 32'(k));
        end
    end

endmodule

// File: rtl/weight_axi_ctrl.sv
// AXI-lite slave that writes and reads back the coupling weights of an NxN
// Ising cell array. Writes become a one-cycle broadcast strobe with a one-hot
// cell select; reads pick one cell's readback word.
// Ports:
//   clk, axi_rst               clock, async active-high reset
//   s_aw*/s_w*/s_b*            AXI-lite write address / data / response
//   s_ar*/s_r*                 AXI-lite read address / data
//   cell_wready                one-cycle write strobe to all cells
//   cell_addr_match [N*N]      one-hot cell select, valid only with cell_wready
//   cell_wdata [32]            write data broadcast to all cells
//   cell_rdata [32*N*N]        flattened readback, cell k at [32k+31:32k]
//
// Write FSM
//   state      | meaning
//   W_IDLE     | waiting for AW and/or W
//   W_HAVE_AW  | address captured, waiting for data
//   W_HAVE_W   | data captured, waiting for address
//   W_STROBE   | single cycle: strobe cells if address and weight are legal
//   W_RESP     | B response held until s_bready
// Read FSM
//   state      | meaning
//   R_IDLE     | accepting AR
//   R_DATA     | R response held until s_rready
module weight_axi_ctrl
    import ising_pkg::*;
#(
    parameter int          N           = 8,
    parameter int          NUM_WEIGHTS = 15,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              axi_rst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [31:0]       s_wdata,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [31:0]       s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              cell_wready,
    output logic [N*N-1:0]    cell_addr_match,
    output logic [31:0]       cell_wdata,
    input  logic [32*N*N-1:0] cell_rdata
);

    localparam int CELLS = N * N;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [31:0]    aw_addr_q;
    logic [31:0]    w_data_q;
    logic [1:0]     bresp_q;
    logic [31:0]    rdata_q;
    logic [1:0]     rresp_q;

    logic [CELLS-1:0] wr_match;
    logic             wr_in_range;
    logic [CELLS-1:0] rd_match;
    logic             rd_in_range;
    logic             w_data_ok;
    logic [31:0]      rd_sel;
    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;

    weight_addr_decode #(.N(N), .ADDR_BASE(ADDR_BASE)) u_wr_decode (
        .addr     (aw_addr_q),
        .match    (wr_match),
        .in_range (wr_in_range)
    );

    weight_addr_decode #(.N(N), .ADDR_BASE(ADDR_BASE)) u_rd_decode (
        .addr     (s_araddr),
        .match    (rd_match),
        .in_range (rd_in_range)
    );

    assign w_data_ok = w_data_q < 32'(NUM_WEIGHTS);
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;
    assign ar_hs     = s_arvalid && s_arready;

    // ---------------- write channel ----------------
    always_comb begin
        wr_next     = wr_state;
        s_awready   = 1'b0;
        s_wready    = 1'b0;
        cell_wready = 1'b0;
        case (wr_state)
            W_IDLE: begin
                s_awready = 1'b1;
                s_wready  = 1'b1;
                if (s_awvalid && s_wvalid) wr_next = W_STROBE;
                else if (s_awvalid)        wr_next = W_HAVE_AW;
                else if (s_wvalid)         wr_next = W_HAVE_W;
            end
            W_HAVE_AW: begin
                s_wready = 1'b1;
                if (s_wvalid) wr_next = W_STROBE;
            end
            W_HAVE_W: begin
                s_awready = 1'b1;
                if (s_awvalid) wr_next = W_STROBE;
            end
            W_STROBE: begin
                cell_wready = wr_in_range && w_data_ok;
                wr_next     = W_RESP;
            end
            W_RESP: begin
                if (s_bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
        // Ready must read low for the whole reset assertion, not just from
        // the next edge, so it is gated directly by the reset input.
        if (axi_rst) begin
            s_awready = 1'b0;
            s_wready  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            wr_state  <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            wr_state <= wr_next;
            if (aw_hs) aw_addr_q <= s_awaddr;
            if (w_hs)  w_data_q  <= s_wdata;
            if (wr_state == W_STROBE) begin
                // A bad address outranks a bad weight.
                if (!wr_in_range)    bresp_q <= RESP_DECERR;
                else if (!w_data_ok) bresp_q <= RESP_SLVERR;
                else                 bresp_q <= RESP_OKAY;
            end
        end
    end

    assign s_bvalid        = (wr_state == W_RESP);
    assign s_bresp         = bresp_q;
    assign cell_wdata      = w_data_q;
    assign cell_addr_match = cell_wready ? wr_match : '0;

    // ---------------- read channel ----------------
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < CELLS; k++) begin
            if (rd_match[k]) rd_sel = cell_rdata[32*k +: 32];
        end
    end

    always_comb begin
        rd_next   = rd_state;
        s_arready = 1'b0;
        case (rd_state)
            R_IDLE: begin
                s_arready = 1'b1;
                if (s_arvalid) rd_next = R_DATA;
            end
            R_DATA: begin
                if (s_rready) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
        if (axi_rst) s_arready = 1'b0;
    end

    // cell_rdata is sampled at the AR edge, so a cell being strobed on the
    // same edge still returns its old contents.
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            rd_state <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) begin
                rdata_q <= rd_sel;
                rresp_q <= rd_in_range ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    assign s_rvalid = (rd_state == R_DATA);
    assign s_rdata  = rdata_q;
    assign s_rresp  = rresp_q;

endmodule

// File: tb/tb_weight_axi_ctrl.sv
// Directed bench for weight_axi_ctrl with N=4, NUM_WEIGHTS=15, ADDR_BASE=0.
module tb_weight_axi_ctrl;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              axi_rst;
    logic              s_awvalid, s_awready;
    logic [31:0]       s_awaddr;
    logic              s_wvalid, s_wready;
    logic [31:0]       s_wdata;
    logic              s_bvalid, s_bready;
    logic [1:0]        s_bresp;
    logic              s_arvalid, s_arready;
    logic [31:0]       s_araddr;
    logic              s_rvalid, s_rready;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              cell_wready;
    logic [N*N-1:0]    cell_addr_match;
    logic [31:0]       cell_wdata;
    logic [32*N*N-1:0] cell_rdata;

    int n_vec = 0;
    int n_err = 0;

    weight_axi_ctrl #(.N(N), .NUM_WEIGHTS(15), .ADDR_BASE(32'h0)) dut (
        .clk             (clk),
        .axi_rst         (axi_rst),
        .s_awvalid       (s_awvalid),
        .s_awready       (s_awready),
        .s_awaddr        (s_awaddr),
        .s_wvalid        (s_wvalid),
        .s_wready        (s_wready),
        .s_wdata         (s_wdata),
        .s_bvalid        (s_bvalid),
        .s_bready        (s_bready),
        .s_bresp         (s_bresp),
        .s_arvalid       (s_arvalid),
        .s_arready       (s_arready),
        .s_araddr        (s_araddr),
        .s_rvalid        (s_rvalid),
        .s_rready        (s_rready),
        .s_rdata         (s_rdata),
        .s_rresp         (s_rresp),
        .cell_wready     (cell_wready),
        .cell_addr_match (cell_addr_match),
        .cell_wdata      (cell_wdata),
        .cell_rdata      (cell_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cell(input int idx, input logic [31:0] val);
        cell_rdata[idx*32 +: 32] = val;
    endtask

    // AW and W offered together; checks strobe cycle and response cycle.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] exp_match, input logic [31:0] exp_strobe,
                            input logic [31:0] exp_resp);
        s_awvalid = 1'b1; s_awaddr = addr;
        s_wvalid  = 1'b1; s_wdata  = data;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("strobe", 32'(cell_wready), exp_strobe);
        chk("match", 32'(cell_addr_match), exp_match);
        if (exp_strobe == 32'd1) chk("wdata", cell_wdata, data);
        chk("bvalid_strobe_cyc", 32'(s_bvalid), 32'd0);
        tick();
        chk("bvalid", 32'(s_bvalid), 32'd1);
        chk("bresp", 32'(s_bresp), exp_resp);
        chk("strobe_off", 32'(cell_wready), 32'd0);
        chk("match_off", 32'(cell_addr_match), 32'd0);
        tick();
        chk("bvalid_done", 32'(s_bvalid), 32'd0);
    endtask

    initial begin
        axi_rst   = 1'b1;
        s_awvalid = 1'b0; s_awaddr = '0;
        s_wvalid  = 1'b0; s_wdata  = '0;
        s_arvalid = 1'b0; s_araddr = '0;
        s_bready  = 1'b1; s_rready = 1'b1;
        cell_rdata = '0;
        for (int k = 0; k < N*N; k++) set_cell(k, 32'h100 + 32'(k));

        // reset state
        #2;
        chk("rst_awready", 32'(s_awready), 32'd0);
        chk("rst_wready", 32'(s_wready), 32'd0);
        chk("rst_arready", 32'(s_arready), 32'd0);
        chk("rst_bvalid", 32'(s_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_strobe", 32'(cell_wready), 32'd0);
        @(posedge clk); @(posedge clk);
        #3 axi_rst = 1'b0;
        #1;
        chk("rel_awready", 32'(s_awready), 32'd1);
        chk("rel_wready", 32'(s_wready), 32'd1);
        chk("rel_arready", 32'(s_arready), 32'd1);
        tick();

        // AW 0x14 + W 7 in the same cycle -> cell 5
        do_write(32'h14, 32'd7, 32'h0020, 32'd1, 32'd0);

        // W 3 three cycles ahead of AW 0x00
        s_wvalid = 1'b1; s_wdata = 32'd3;
        tick();
        s_wvalid = 1'b0;
        chk("have_w_wready", 32'(s_wready), 32'd0);
        chk("have_w_awready", 32'(s_awready), 32'd1);
        chk("have_w_strobe", 32'(cell_wready), 32'd0);
        tick();
        tick();
        s_awvalid = 1'b1; s_awaddr = 32'h0;
        tick();
        s_awvalid = 1'b0;
        chk("late_aw_strobe", 32'(cell_wready), 32'd1);
        chk("late_aw_match", 32'(cell_addr_match), 32'h0001);
        chk("late_aw_wdata", cell_wdata, 32'd3);
        tick();
        chk("late_aw_bvalid", 32'(s_bvalid), 32'd1);
        chk("late_aw_bresp", 32'(s_bresp), 32'd0);
        tick();

        // error responses and the last-cell / last-weight boundary
        do_write(32'h40, 32'd1, 32'h0, 32'd0, 32'd3);
        do_write(32'h04, 32'd15, 32'h0, 32'd0, 32'd2);
        do_write(32'h40, 32'd20, 32'h0, 32'd0, 32'd3);
        do_write(32'h3C, 32'd14, 32'h8000, 32'd1, 32'd0);
        do_write(32'h27, 32'd1, 32'h0200, 32'd1, 32'd0);

        // B backpressure
        s_bready = 1'b0;
        s_awvalid = 1'b1; s_awaddr = 32'h08;
        s_wvalid  = 1'b1; s_wdata  = 32'd4;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("bp_match", 32'(cell_addr_match), 32'h0004);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", 32'(s_bvalid), 32'd1);
            chk("bp_bresp", 32'(s_bresp), 32'd0);
            chk("bp_awready", 32'(s_awready), 32'd0);
            chk("bp_wready", 32'(s_wready), 32'd0);
            tick();
        end
        s_bready = 1'b1;
        chk("bp_bvalid_last", 32'(s_bvalid), 32'd1);
        tick();
        chk("bp_released", 32'(s_bvalid), 32'd0);
        do_write(32'h0C, 32'd2, 32'h0008, 32'd1, 32'd0);

        // read with R backpressure
        set_cell(5, 32'd9);
        s_rready  = 1'b0;
        s_arvalid = 1'b1; s_araddr = 32'h14;
        chk("ar_ready", 32'(s_arready), 32'd1);
        tick();
        s_arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rd_rvalid", 32'(s_rvalid), 32'd1);
            chk("rd_rdata", s_rdata, 32'd9);
            chk("rd_rresp", 32'(s_rresp), 32'd0);
            chk("rd_arready", 32'(s_arready), 32'd0);
            if (i == 0) set_cell(5, 32'd99);
            tick();
        end
        s_rready = 1'b1;
        chk("rd_rvalid_last", 32'(s_rvalid), 32'd1);
        tick();
        chk("rd_done", 32'(s_rvalid), 32'd0);
        chk("rd_arready_back", 32'(s_arready), 32'd1);

        // out-of-range read
        s_arvalid = 1'b1; s_araddr = 32'h40;
        tick();
        s_arvalid = 1'b0;
        chk("oor_rvalid", 32'(s_rvalid), 32'd1);
        chk("oor_rdata", s_rdata, 32'd0);
        chk("oor_rresp", 32'(s_rresp), 32'd3);
        tick();

        // read of cell 2 on the edge it is strobed returns the old value
        set_cell(2, 32'd11);
        s_awvalid = 1'b1; s_awaddr = 32'h08;
        s_wvalid  = 1'b1; s_wdata  = 32'd5;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_arvalid = 1'b1; s_araddr = 32'h08;
        chk("rw_strobe", 32'(cell_wready), 32'd1);
        tick();
        set_cell(2, 32'd5);
        s_arvalid = 1'b0;
        chk("rw_rvalid", 32'(s_rvalid), 32'd1);
        chk("rw_old_value", s_rdata, 32'd11);
        tick();
        s_arvalid = 1'b1; s_araddr = 32'h08;
        tick();
        s_arvalid = 1'b0;
        chk("rw_new_value", s_rdata, 32'd5);
        tick();

        // reset while holding an address without data
        s_awvalid = 1'b1; s_awaddr = 32'h10;
        tick();
        s_awvalid = 1'b0;
        chk("hav_wready", 32'(s_wready), 32'd1);
        chk("hav_awready", 32'(s_awready), 32'd0);
        #2 axi_rst = 1'b1;
        #1;
        chk("mid_awready", 32'(s_awready), 32'd0);
        chk("mid_wready", 32'(s_wready), 32'd0);
        chk("mid_arready", 32'(s_arready), 32'd0);
        chk("mid_bvalid", 32'(s_bvalid), 32'd0);
        chk("mid_rvalid", 32'(s_rvalid), 32'd0);
        chk("mid_strobe", 32'(cell_wready), 32'd0);
        chk("mid_match", 32'(cell_addr_match), 32'd0);
        chk("mid_bresp", 32'(s_bresp), 32'd0);
        chk("mid_rresp", 32'(s_rresp), 32'd0);
        chk("mid_rdata", s_rdata, 32'd0);
        chk("mid_cell_wdata", cell_wdata, 32'd0);
        #2 axi_rst = 1'b0;
        #1;
        chk("post_awready", 32'(s_awready), 32'd1);
        chk("post_wready", 32'(s_wready), 32'd1);
        // the aborted address is gone: a lone W now waits for a fresh AW
        s_wvalid = 1'b1; s_wdata = 32'd6;
        tick();
        s_wvalid = 1'b0;
        chk("post_strobe", 32'(cell_wready), 32'd0);
        chk("post_bvalid", 32'(s_bvalid), 32'd0);
        chk("post_have_w", 32'(s_awready), 32'd1);
        s_awvalid = 1'b1; s_awaddr = 32'h04;
        tick();
        s_awvalid = 1'b0;
        chk("post_match", 32'(cell_addr_match), 32'h0002);
        chk("post_wdata", cell_wdata, 32'd6);
        tick();
        chk("post_bresp_valid", 32'(s_bvalid), 32'd1);
        chk("post_bresp", 32'(s_bresp), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
